// File: rtl/syn_line_rasterizer.sv
//==============================================================================
// Module      : syn_gpu_pkg / syn_pxl_xfr_intf / syn_line_rasterizer
// Description : Line rasterizer stage of the grapheme GPU pipeline. Accepts a
//               line job (two end points and a colour), walks the line with an
//               all-octant integer Bresenham algorithm and emits one pixel per
//               accepted transfer on a pixel-transfer master port.
//
// Ports (syn_line_rasterizer):
//   clk_ir       in   1       single clock
//   rst_il       in   1       synchronous active-high reset
//   job_valid_i  in   1       job request
//   job_ready_o  out  1       block idle and able to take a job
//   x0_i/y0_i    in   WIDTHX/WIDTHY   start point
//   x1_i/y1_i    in   WIDTHX/WIDTHY   end point
//   colour_i     in   pxl_hsi_t       colour applied to every pixel
//   done_o       out  1       one-cycle pulse after the final pixel transfer
//   pxl_o        syn_pxl_xfr_intf.master   pixel stream out (ready is input)
//
// Revision    : 1.0  initial release
//==============================================================================
`default_nettype none

package syn_gpu_pkg;
    localparam int P_X_W    = 10;
    localparam int P_Y_W    = 10;
    localparam int P_MISC_W = 8;

    typedef struct packed {
        logic [7:0] hue;
        logic [7:0] sat;
        logic [7:0] inten;
    } pxl_hsi_t;
endpackage

interface syn_pxl_xfr_intf #(
    parameter int WIDTHX = syn_gpu_pkg::P_X_W,
    parameter int WIDTHY = syn_gpu_pkg::P_Y_W
);
    logic                                pxl_wr_valid;
    logic                                pxl_rd_valid;
    logic [WIDTHX-1:0]                   posx;
    logic [WIDTHY-1:0]                   posy;
    syn_gpu_pkg::pxl_hsi_t               pxl;
    logic [syn_gpu_pkg::P_MISC_W-1:0]    misc_info_dist;
    logic [syn_gpu_pkg::P_MISC_W-1:0]    misc_info_norm;
    logic                                ready;

    modport master (
        output pxl_wr_valid, pxl_rd_valid, posx, posy, pxl,
               misc_info_dist, misc_info_norm,
        input  ready
    );

    modport slave (
        input  pxl_wr_valid, pxl_rd_valid, posx, posy, pxl,
               misc_info_dist, misc_info_norm,
        output ready
    );
endinterface

module syn_line_rasterizer #(
    parameter int WIDTHX = syn_gpu_pkg::P_X_W,
    parameter int WIDTHY = syn_gpu_pkg::P_Y_W
) (
    input  logic                  clk_ir,
    input  logic                  rst_il,
    input  logic                  job_valid_i,
    output logic                  job_ready_o,
    input  logic [WIDTHX-1:0]     x0_i,
    input  logic [WIDTHY-1:0]     y0_i,
    input  logic [WIDTHX-1:0]     x1_i,
    input  logic [WIDTHY-1:0]     y1_i,
    input  syn_gpu_pkg::pxl_hsi_t colour_i,
    output logic                  done_o,
    syn_pxl_xfr_intf.master       pxl_o
);

    // Two guard bits: one for the sign, one so dx+dy and the running error
    // never overflow. The doubled error gets one more bit on top of that.
    localparam int EW = ((WIDTHX > WIDTHY) ? WIDTHX : WIDTHY) + 2;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SETUP = 2'd1;
    localparam logic [1:0] S_DRAW  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [WIDTHX-1:0] c_ONE_X = WIDTHX'(1);
    localparam logic [WIDTHY-1:0] c_ONE_Y = WIDTHY'(1);

    logic [1:0]             r_state;
    logic [1:0]             w_state_nxt;

    logic [WIDTHX-1:0]      r_x0, r_x1, r_curx;
    logic [WIDTHY-1:0]      r_y0, r_y1, r_cury;
    syn_gpu_pkg::pxl_hsi_t  r_colour;
    logic signed [EW-1:0]   r_dx, r_dy, r_err;
    logic                   r_sx_neg, r_sy_neg;

    logic signed [EW-1:0]   w_x0s, w_x1s, w_y0s, w_y1s;
    logic signed [EW-1:0]   w_ddx, w_ddy, w_dx_abs, w_dy_neg;
    logic signed [EW:0]     w_e2, w_dx_x, w_dy_x;
    logic signed [EW-1:0]   w_add_dx, w_add_dy, w_err_nxt;
    logic                   w_step_x, w_step_y;
    logic                   w_at_end, w_xfer;

    //--------------------------------------------------------------------------
    // Setup arithmetic: coordinates zero-extended into the signed error width
    //--------------------------------------------------------------------------
    assign w_x0s    = $signed({{(EW-WIDTHX){1'b0}}, r_x0});
    assign w_x1s    = $signed({{(EW-WIDTHX){1'b0}}, r_x1});
    assign w_y0s    = $signed({{(EW-WIDTHY){1'b0}}, r_y0});
    assign w_y1s    = $signed({{(EW-WIDTHY){1'b0}}, r_y1});
    assign w_ddx    = w_x1s - w_x0s;
    assign w_ddy    = w_y1s - w_y0s;
    assign w_dx_abs = w_ddx[EW-1] ? -w_ddx : w_ddx;
    // dy is kept as the negated magnitude, as the classic formulation expects
    assign w_dy_neg = w_ddy[EW-1] ? w_ddy : -w_ddy;

    //--------------------------------------------------------------------------
    // Step decision: both tests use the error value from before this step
    //--------------------------------------------------------------------------
    assign w_e2      = $signed({r_err, 1'b0});
    assign w_dx_x    = $signed({r_dx[EW-1], r_dx});
    assign w_dy_x    = $signed({r_dy[EW-1], r_dy});
    assign w_step_x  = (w_e2 >= w_dy_x);
    assign w_step_y  = (w_e2 <= w_dx_x);
    assign w_add_dy  = w_step_x ? r_dy : '0;
    assign w_add_dx  = w_step_y ? r_dx : '0;
    assign w_err_nxt = r_err + w_add_dy + w_add_dx;

    assign w_at_end  = (r_curx == r_x1) && (r_cury == r_y1);
    assign w_xfer    = (r_state == S_DRAW) && pxl_o.ready;

    //--------------------------------------------------------------------------
    // FSM: state register
    //--------------------------------------------------------------------------
    always_ff @(posedge clk_ir) begin
        if (rst_il) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    //--------------------------------------------------------------------------
    // FSM: next-state logic
    //--------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (job_valid_i) w_state_nxt = S_SETUP;
            S_SETUP: w_state_nxt = S_DRAW;
            S_DRAW:  if (w_xfer && w_at_end) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    //--------------------------------------------------------------------------
    // FSM: outputs, decoded straight from the state register
    //--------------------------------------------------------------------------
    always_comb begin
        job_ready_o        = 1'b0;
        done_o             = 1'b0;
        pxl_o.pxl_wr_valid = 1'b0;
        case (r_state)
            S_IDLE:  job_ready_o        = 1'b1;
            S_DRAW:  pxl_o.pxl_wr_valid = 1'b1;
            S_DONE:  done_o             = 1'b1;
            default: ;
        endcase
    end

    assign pxl_o.posx           = r_curx;
    assign pxl_o.posy           = r_cury;
    assign pxl_o.pxl            = r_colour;
    assign pxl_o.pxl_rd_valid   = 1'b0;
    assign pxl_o.misc_info_dist = '0;
    assign pxl_o.misc_info_norm = '0;

    //--------------------------------------------------------------------------
    // Datapath
    //--------------------------------------------------------------------------
    always_ff @(posedge clk_ir) begin
        if (rst_il) begin
            r_x0     <= '0;
            r_y0     <= '0;
            r_x1     <= '0;
            r_y1     <= '0;
            r_colour <= '0;
            r_curx   <= '0;
            r_cury   <= '0;
            r_dx     <= '0;
            r_dy     <= '0;
            r_err    <= '0;
            r_sx_neg <= 1'b0;
            r_sy_neg <= 1'b0;
        end else begin
            if ((r_state == S_IDLE) && job_valid_i) begin
                r_x0     <= x0_i;
                r_y0     <= y0_i;
                r_x1     <= x1_i;
                r_y1     <= y1_i;
                r_colour <= colour_i;
            end

            if (r_state == S_SETUP) begin
                r_dx     <= w_dx_abs;
                r_dy     <= w_dy_neg;
                r_err    <= w_dx_abs + w_dy_neg;
                r_sx_neg <= (r_x1 < r_x0);
                r_sy_neg <= (r_y1 < r_y0);
                r_curx   <= r_x0;
                r_cury   <= r_y0;
            end

            // Position and error only advance on an actual transfer, so the
            // presented pixel stays put under backpressure.
            if (w_xfer && !w_at_end) begin
                r_err <= w_err_nxt;
                if (w_step_x) begin
                    r_curx <= r_sx_neg ? (r_curx - c_ONE_X) : (r_curx + c_ONE_X);
                end
                if (w_step_y) begin
                    r_cury <= r_sy_neg ? (r_cury - c_ONE_Y) : (r_cury + c_ONE_Y);
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_syn_line_rasterizer.sv
//==============================================================================
// Module      : tb_syn_line_rasterizer
// Description : Scoreboard bench for syn_line_rasterizer. Directed lines plus
//               random lines checked against a reference line model.
// Revision    : 1.0  initial release
//==============================================================================
`default_nettype none

module tb_syn_line_rasterizer;

    localparam int XW = syn_gpu_pkg::P_X_W;
    localparam int YW = syn_gpu_pkg::P_Y_W;

    logic                  clk;
    logic                  rst;
    logic                  job_valid;
    logic                  job_ready;
    logic                  done;
    logic [XW-1:0]         x0, x1;
    logic [YW-1:0]         y0, y1;
    syn_gpu_pkg::pxl_hsi_t colour;
    logic                  rdy;

    syn_pxl_xfr_intf #(.WIDTHX(XW), .WIDTHY(YW)) u_pxl ();
    assign u_pxl.ready = rdy;

    syn_line_rasterizer #(.WIDTHX(XW), .WIDTHY(YW)) u_dut (
        .clk_ir      (clk),
        .rst_il      (rst),
        .job_valid_i (job_valid),
        .job_ready_o (job_ready),
        .x0_i        (x0),
        .y0_i        (y0),
        .x1_i        (x1),
        .y1_i        (y1),
        .colour_i    (colour),
        .done_o      (done),
        .pxl_o       (u_pxl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          is_done;
        int          x;
        int          y;
        logic [23:0] c;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_xfer   = 0;
    int   bp_mode  = 0;
    int   pat_idx  = 0;
    bit   pat[7]   = '{1, 0, 0, 1, 0, 1, 1};

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic push_px(input int x, input int y, input logic [23:0] c);
        exp_t e;
        e.is_done = 1'b0; e.x = x; e.y = y; e.c = c;
        sb.push_back(e);
    endtask

    task automatic push_done();
        exp_t e;
        e.is_done = 1'b1; e.x = 0; e.y = 0; e.c = '0;
        sb.push_back(e);
    endtask

    // Reference line: the error-term walk described for the stage, in plain ints
    task automatic model_line(input int ax0, input int ay0, input int ax1,
                              input int ay1, input logic [23:0] c);
        int dx, dy, sx, sy, err, e2, x, y;
        dx  = (ax1 >= ax0) ? ax1 - ax0 : ax0 - ax1;
        dy  = (ay1 >= ay0) ? ay0 - ay1 : ay1 - ay0;
        sx  = (ax1 >= ax0) ? 1 : -1;
        sy  = (ay1 >= ay0) ? 1 : -1;
        err = dx + dy;
        x   = ax0;
        y   = ay0;
        forever begin
            push_px(x, y, c);
            if (x == ax1 && y == ay1) break;
            e2 = 2 * err;
            if (e2 >= dy) begin err += dy; x += sx; end
            if (e2 <= dx) begin err += dx; y += sy; end
        end
        push_done();
    endtask

    // Slave-side ready generation
    always @(posedge clk) begin
        #1;
        case (bp_mode)
            0:       rdy = 1'b1;
            1:       rdy = 1'($urandom_range(0, 1));
            default: begin rdy = pat[pat_idx % 7]; pat_idx++; end
        endcase
    end

    // Monitor: compares every transfer and done pulse against the scoreboard
    logic            prev_v, prev_r, prev_done, prev_xfer;
    logic [XW-1:0]   prev_x;
    logic [YW-1:0]   prev_y;
    logic [23:0]     prev_c;

    always @(negedge clk) begin
        if (rst) begin
            prev_v = 0; prev_r = 0; prev_done = 0; prev_xfer = 0;
        end else begin
            if (prev_v && !prev_r) begin
                chk("hold_valid", u_pxl.pxl_wr_valid, 1);
                chk("hold_pixel", {u_pxl.posx, u_pxl.posy, u_pxl.pxl},
                    {prev_x, prev_y, prev_c});
            end
            if (prev_done) chk("ready_after_done", job_ready, 1);
            if (u_pxl.pxl_wr_valid && rdy) begin
                n_xfer++;
                chk("rd_valid_tied", {u_pxl.pxl_rd_valid, u_pxl.misc_info_dist,
                    u_pxl.misc_info_norm}, 0);
                if (sb.size() == 0 || sb[0].is_done) begin
                    n_checks++; n_errors++;
                    $display("FAIL pixel_extra actual=(%0d,%0d) required=none",
                             u_pxl.posx, u_pxl.posy);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("pixel_x", u_pxl.posx, e.x);
                    chk("pixel_y", u_pxl.posy, e.y);
                    chk("pixel_colour", u_pxl.pxl, e.c);
                end
            end
            if (done) begin
                chk("done_after_last_xfer", prev_xfer, 1);
                chk("not_ready_in_done", job_ready, 0);
                if (sb.size() == 0 || !sb[0].is_done) begin
                    n_checks++; n_errors++;
                    $display("FAIL done_unexpected actual=1 required=0 pending=%0d",
                             sb.size());
                end else begin
                    void'(sb.pop_front());
                    n_checks++;
                end
            end
            prev_v    = u_pxl.pxl_wr_valid;
            prev_r    = rdy;
            prev_done = done;
            prev_xfer = u_pxl.pxl_wr_valid && rdy;
            prev_x    = u_pxl.posx;
            prev_y    = u_pxl.posy;
            prev_c    = u_pxl.pxl;
        end
    end

    task automatic wait_ready_idle(output bit ok);
        int cnt = 0;
        while (!job_ready && cnt < 5000) begin
            @(posedge clk); #1; cnt++;
        end
        ok = job_ready;
        if (!ok) begin
            n_checks++; n_errors++;
            $display("FAIL job_ready_timeout actual=0 required=1");
        end
    endtask

    // Issue one job (scoreboard already loaded) and wait for it to finish.
    // Caller is positioned just after a rising edge.
    task automatic run_job(input int ax0, input int ay0, input int ax1,
                           input int ay1, input logic [23:0] c, input bit poke);
        int L, cnt;
        bit ok;
        L = sb.size() - 1;
        wait_ready_idle(ok);
        if (!ok) return;
        x0 = XW'(ax0); y0 = YW'(ay0); x1 = XW'(ax1); y1 = YW'(ay1);
        colour = c; job_valid = 1'b1;
        @(posedge clk); #1;
        cnt = 0;
        job_valid = 1'b0;
        x0 = XW'($urandom); y0 = YW'($urandom); x1 = XW'($urandom);
        y1 = YW'($urandom); colour = 24'($urandom);
        chk("setup_no_valid", u_pxl.pxl_wr_valid, 0);
        chk("busy_not_ready", job_ready, 0);
        if (poke) job_valid = 1'b1;
        @(posedge clk); #1; cnt++;
        chk("first_valid_latency", u_pxl.pxl_wr_valid, 1);
        if (poke) begin
            @(posedge clk); #1; cnt++;
            chk("poke_not_ready", job_ready, 0);
            job_valid = 1'b0;
        end
        while (!job_ready && cnt < 5000) begin
            @(posedge clk); #1; cnt++;
        end
        chk("job_finished", job_ready, 1);
        if (bp_mode == 0) chk("job_spacing", cnt, L + 2);
        chk("sb_drained", sb.size(), 0);
    endtask

    initial begin
        logic [23:0] col;
        int start, cnt;
        bit ok;
        rst = 1'b1; job_valid = 1'b0; rdy = 1'b1;
        x0 = '0; y0 = '0; x1 = '0; y1 = '0; colour = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_job_ready", job_ready, 1);
        chk("rst_done", done, 0);
        chk("rst_wr_valid", u_pxl.pxl_wr_valid, 0);
        chk("rst_rd_valid", u_pxl.pxl_rd_valid, 0);
        chk("rst_pos", {u_pxl.posx, u_pxl.posy}, 0);
        chk("rst_pxl", u_pxl.pxl, 0);
        chk("rst_misc", {u_pxl.misc_info_dist, u_pxl.misc_info_norm}, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Horizontal line
        col = 24'($urandom);
        for (int i = 0; i < 4; i++) push_px(i, 0, col);
        push_done();
        run_job(0, 0, 3, 0, col, 0);

        // Reverse diagonal
        col = 24'($urandom);
        for (int i = 0; i < 4; i++) push_px(5 - i, 5 - i, col);
        push_done();
        run_job(5, 5, 2, 2, col, 0);

        // Steep line
        col = 24'($urandom);
        push_px(0, 0, col); push_px(0, 1, col); push_px(1, 2, col); push_px(1, 3, col);
        push_done();
        run_job(0, 0, 1, 3, col, 0);

        // Degenerate point
        col = 24'($urandom);
        push_px(7, 9, col);
        push_done();
        run_job(7, 9, 7, 9, col, 0);

        // Backpressure pattern with a job request while busy
        pat_idx = 0; bp_mode = 2;
        col = 24'($urandom);
        for (int i = 0; i < 4; i++) push_px(i, 0, col);
        push_done();
        run_job(0, 0, 3, 0, col, 1);
        bp_mode = 0;

        // Reset in the middle of a line
        col = 24'($urandom);
        for (int i = 0; i <= 10; i++) push_px(i, 0, col);
        push_done();
        wait_ready_idle(ok);
        start = n_xfer;
        x0 = '0; y0 = '0; x1 = XW'(10); y1 = '0; colour = col; job_valid = 1'b1;
        @(posedge clk); #1;
        job_valid = 1'b0;
        cnt = 0;
        while (n_xfer < start + 2 && cnt < 100) begin
            @(posedge clk); #1; cnt++;
        end
        chk("reset_wait_two_pixels", n_xfer - start, 2);
        rst = 1'b1;
        sb.delete();
        @(posedge clk); #1;
        chk("midreset_wr_valid", u_pxl.pxl_wr_valid, 0);
        chk("midreset_job_ready", job_ready, 1);
        chk("midreset_done", done, 0);
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        col = 24'($urandom);
        for (int i = 0; i < 5; i++) push_px(2 + i, 3, col);
        push_done();
        run_job(2, 3, 6, 3, col, 0);

        // Full-range extremes
        col = 24'($urandom);
        model_line(0, 0, (1 << XW) - 1, 1, col);
        run_job(0, 0, (1 << XW) - 1, 1, col, 0);
        bp_mode = 1;
        col = 24'($urandom);
        model_line((1 << XW) - 1, (1 << YW) - 1, 0, 0, col);
        run_job((1 << XW) - 1, (1 << YW) - 1, 0, 0, col, 0);

        // Random lines, alternating free-running and random backpressure
        for (int j = 0; j < 40; j++) begin
            int rx0, ry0, rx1, ry1;
            bp_mode = j % 2;
            rx0 = $urandom_range(0, 31); ry0 = $urandom_range(0, 31);
            rx1 = $urandom_range(0, 31); ry1 = $urandom_range(0, 31);
            col = 24'($urandom);
            model_line(rx0, ry0, rx1, ry1, col);
            run_job(rx0, ry0, rx1, ry1, col, 0);
        end

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
